// File: rtl/match_controller.sv
// Cricket match sequencer: bowl pulses -> delivery strobes, ball/over counting, innings break, result.
// Optional AUTO_BOWL_EN adds a free-running auto-bowl pulse generator ORed with bowl_btn.
module match_controller #(
  parameter int OVERS          = 2,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WICKETS    = 10,
  parameter int AUTO_PERIOD    = 50_000_000
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       bowl_btn,
  input  logic [3:0] lfsr_out,
  input  logic [7:0] runs,
  input  logic [3:0] wickets,
  output logic       delivery,
  output logic       teamSwitch,
  output logic       gameOver,
  output logic       innings,
  output logic [2:0] balls,
  output logic [3:0] overs,
  output logic [7:0] target,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  // Handshake: bowl requests are single-cycle pulses accepted only in BOWL_WAIT
  // (or BREAK, where they just resume play); a request in any other state is dropped.
  typedef enum logic [2:0] {
    BOWL_WAIT = 3'd0,
    DELIVER   = 3'd1,
    SETTLE    = 3'd2,
    EVAL      = 3'd3,
    BREAK     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] outcome;
  logic       bowl_req;

`ifdef AUTO_BOWL_EN
  localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [CW-1:0] auto_cnt;
  logic          auto_pulse;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      auto_cnt   <= '0;
      auto_pulse <= 1'b0;
    end else if (state != DONE) begin
      if (auto_cnt == CW'(AUTO_PERIOD - 1)) begin
        auto_cnt   <= '0;
        auto_pulse <= 1'b1;
      end else begin
        auto_cnt   <= auto_cnt + 1'b1;
        auto_pulse <= 1'b0;
      end
    end else begin
      auto_pulse <= 1'b0;
    end
  end

  assign bowl_req = bowl_btn | auto_pulse;
`else
  logic unused_auto_period;
  assign unused_auto_period = (AUTO_PERIOD < 0);
  assign bowl_req = bowl_btn;
`endif

  logic       legal;
  logic [3:0] balls_sum;
  logic       rollover;
  logic [2:0] balls_next;
  logic [3:0] overs_next;
  logic       innings_end;
  logic       chased;
  logic       tie;

  // Counters are evaluated one step ahead so the innings-end test sees the post-ball overs.
  always_comb begin
    legal       = (outcome != 4'd13) && (outcome != 4'd14);
    balls_sum   = {1'b0, balls} + {3'b000, legal};
    rollover    = (balls_sum == 4'(BALLS_PER_OVER));
    balls_next  = rollover ? 3'd0 : balls_sum[2:0];
    overs_next  = overs + {3'b000, rollover};
    innings_end = (wickets >= 4'(MAX_WICKETS)) || (overs_next == 4'(OVERS));
    chased      = innings && (runs >= target);
    tie         = (runs == target - 8'd1);
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state      <= BOWL_WAIT;
      outcome    <= 4'd0;
      delivery   <= 1'b0;
      teamSwitch <= 1'b0;
      gameOver   <= 1'b0;
      innings    <= 1'b0;
      balls      <= 3'd0;
      overs      <= 4'd0;
      target     <= 8'd0;
      winner     <= 2'b00;
    end else begin
      delivery <= 1'b0;
      case (state)
        BOWL_WAIT: begin
          if (bowl_req) begin
            state    <= DELIVER;
            delivery <= 1'b1;
          end
        end
        DELIVER: begin
          outcome <= lfsr_out;
          state   <= SETTLE;
        end
        SETTLE: state <= EVAL;
        EVAL: begin
          balls <= balls_next;
          overs <= overs_next;
          if (chased) begin
            winner   <= 2'b10;
            gameOver <= 1'b1;
            state    <= DONE;
          end else if (innings_end) begin
            if (!innings) begin
              target     <= runs + 8'd1;
              teamSwitch <= 1'b1;
              innings    <= 1'b1;
              state      <= BREAK;
            end else begin
              winner   <= tie ? 2'b11 : 2'b01;
              gameOver <= 1'b1;
              state    <= DONE;
            end
          end else begin
            state <= BOWL_WAIT;
          end
        end
        // First-innings figures stay visible through the break; cleared when play resumes.
        BREAK: begin
          if (bowl_req) begin
            balls <= 3'd0;
            overs <= 4'd0;
            state <= BOWL_WAIT;
          end
        end
        DONE:    state <= DONE;
        default: state <= BOWL_WAIT;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
